mhpm_counters: RTL and testbench
================================

# mhpm_counters

Parametrised machine performance-monitor unit: mcycle, minstret, NUM_HPM programmable mhpmcounters with event selectors, mcountinhibit, and optional per-counter overflow interrupt. Sits in the CSR file beside the other machine CSR banks. Decodes its own 12-bit CSR address range and returns read data and an illegal-address flag to the CSR mux. Counts single-cycle event pulses from the core's event vector.

## Interface
- NUM_HPM, 4: number of implemented mhpmcounter/mhpmevent pairs, 1..29, indices 3..3+NUM_HPM-1.
- CNT_WIDTH, 64: width of every counter, 33..64.
- NUM_EVENTS, 16: width of event_vec, 1..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- addr  in  12  CSR address.
- wr  in  1  single-cycle write strobe; caller asserts only when illegal_address=0.
- write_mode  in  write_mode_t  CSR_WRITE / CSR_SET / CSR_CLEAR.
- din  in  32  CSR write operand.
- dout  out  32  read data, combinational from addr.
- illegal_address  out  1  addr not in this unit's map, combinational.
- retire  in  1  one instruction retired this cycle.
- event_vec  in  NUM_EVENTS  per-cycle event pulses; bit e-1 is event code e.
- overflow_irq  out  1  OR of all enabled overflow flags, registered.

## Operation
- Map: 0x320 mcountinhibit; 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi; 0xB03+k/0xB83+k mhpmcounter lo/hi; 0x323+k mhpmevent, k=0..28.
- k >= NUM_HPM: reads 0, writes ignored, illegal_address=0. Any other address: dout=0, illegal_address=1.
- Write value: CSR_WRITE din; CSR_SET old|din; CSR_CLEAR old&~din. old is the current dout.
- mcountinhibit: bits 0, 2, 3..2+NUM_HPM are writable. All other bits read 0.
- mhpmevent[7:0] is the event code. Code 0 or code > NUM_EVENTS never counts. Bits [30:8] read 0.
- Counters are CNT_WIDTH wide and writable.
  - Hi half read zero-extends bits above CNT_WIDTH-1.
  - Hi write loads bits [CNT_WIDTH-1:32]; lo write loads [31:0].
- Per cycle, each counter increments by 1 when its condition holds and its inhibit bit is 0:
  - mcycle: always.
  - minstret: retire.
  - hpm k: selected event bit.
- Same-cycle CSR write to any half of a counter: the write wins and that cycle's increment is dropped.
- Wrap: all-ones + 1 gives 0.
- Writes to mhpmevent or mcountinhibit take effect for counting from the next cycle.

## Timing
- Reset (async assert): all counters, mhpmevent, mcountinhibit and OF bits = 0; overflow_irq = 0. dout/illegal_address follow addr combinationally.
- Event or retire at cycle N: the count is visible on dout in cycle N+1.
- CSR write at edge N: the value is visible at N+1. A read in the same cycle as a write returns the old value.
- Reset asserted mid-count: immediate clear, no partial increment. Counting resumes on the first edge after deassertion.
- overflow_irq rises one cycle after the OF bit sets. It falls one cycle after the last OF bit clears.

## Configuration
- HPM_OVERFLOW_IRQ_EN defined:
  - mhpmevent bit 31 is OF: sticky, set on the cycle counter k wraps.
  - If a CSR write sets OF in the same cycle as a wrap, OF=1.
  - OF is cleared by a CSR write of 0.
  - overflow_irq = registered OR of all OF.
- Undefined: bit 31 reads 0, writes to it are ignored, overflow_irq tied 0.

## Test plan
- Reset, then run 10 cycles with no inhibit -> mcycle lo = 10, minstret = 0, all hpm = 0, overflow_irq = 0.
- mhpmevent3=2, pulse event_vec[1] 5 times, set mcountinhibit bit 3, pulse 3 more -> mhpmcounter3 = 5. Read 0xB04 with NUM_HPM=1 -> 0, illegal_address=0. Read 0x7C0 -> 0, illegal_address=1.
- CSR_WRITE 0xB02=0xFFFFFFFF, 0xB82=0 with retire held high -> after the writes minstret counts 0x0_FFFFFFFF, then 0x1_00000000 (carry into hi).
- Write mhpmcounter3 lo while its event fires the same cycle -> exactly the written value, no +1. CSR_SET 0x320 din=0x5 then CSR_CLEAR din=0x1 -> 0x4.
- HPM_OVERFLOW_IRQ_EN, CNT_WIDTH=64: load hpm3 to all-ones, fire event once -> counter 0, mhpmevent3[31]=1, overflow_irq=1 next cycle. CSR_CLEAR bit 31 -> irq 0 one cycle later.
- Assert rst asynchronously mid-cycle with nonzero counters -> all state 0 before the next clk edge.

Source files
------------

// File: rtl/mhpm_counters_pkg.sv
// Shared types for the machine performance-monitor CSR bank.
package mhpm_counters_pkg;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2
  } write_mode_t;

endpackage

// File: rtl/mhpm_counters_if.sv
// CSR access bus between the CSR mux (master) and the performance-counter bank (slave).
interface mhpm_counters_if;
  import mhpm_counters_pkg::*;

  logic [11:0] addr;
  logic        wr;
  write_mode_t write_mode;
  logic [31:0] din;
  logic [31:0] dout;
  logic        illegal_address;

  modport master (output addr, wr, write_mode, din, input dout, illegal_address);
  modport slave  (input addr, wr, write_mode, din, output dout, illegal_address);

endinterface

// File: rtl/mhpm_counters.sv
// Machine performance counters: mcycle, minstret, NUM_HPM event counters, mcountinhibit.
// Define HPM_OVERFLOW_IRQ_EN to add sticky per-counter OF bits (mhpmevent[31]) and overflow_irq.
module mhpm_counters
  import mhpm_counters_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mhpm_counters_if.slave        bus,
  input  logic                  retire,
  input  logic [NUM_EVENTS-1:0] event_vec,
  output logic                  overflow_irq
);

  // Counter slot 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k).
  localparam int NCNT = NUM_HPM + 2;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [31:0]        inhibit_q, inhibit_d;
  logic [31:0]        rd_data;
  logic               illegal;
  logic [31:0]        wval;
  logic [31:0]        cnt_lo [NCNT];
  logic [31:0]        cnt_hi [NCNT];
  logic [NCNT-1:0]    sel_lo, sel_hi;
  logic [31:0]        evt_rd [NUM_HPM];
  logic [NUM_HPM-1:0] sel_evt, evt_hit, of_flags;
  logic [255:0]       ev_pad;
  logic               overflow_irq_q, overflow_irq_d;
`ifdef HPM_OVERFLOW_IRQ_EN
  logic [NUM_HPM-1:0] hpm_wrap;
`endif

  assign ev_pad = 256'(event_vec);

  // Read side; also supplies the "old" value for set/clear writes.
  always_comb begin
    rd_data = '0;
    illegal = 1'b1;
    if (bus.addr == 12'h320) begin
      illegal = 1'b0;
      rd_data = inhibit_q;
    end
    if (bus.addr >= 12'h323 && bus.addr <= 12'h33F) illegal = 1'b0;
    if ((bus.addr[11:5] == 7'b1011000 || bus.addr[11:5] == 7'b1011100) && bus.addr[4:0] != 5'd1)
      illegal = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      if (sel_lo[i]) rd_data = cnt_lo[i];
      if (sel_hi[i]) rd_data = cnt_hi[i];
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      if (sel_evt[i]) rd_data = evt_rd[i];
    end
  end

  assign bus.dout            = rd_data;
  assign bus.illegal_address = illegal;

  always_comb begin
    case (bus.write_mode)
      CSR_SET:   wval = rd_data | bus.din;
      CSR_CLEAR: wval = rd_data & ~bus.din;
      default:   wval = bus.din;
    endcase
  end

  always_comb begin
    inhibit_d = inhibit_q;
    if (bus.wr && bus.addr == 12'h320) inhibit_d = wval & INH_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inhibit_q <= '0;
    else     inhibit_q <= inhibit_d;
  end

  for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
    localparam logic [11:0] LO_ADDR = (gi == 0) ? 12'hB00 : 12'(32'hB01 + gi);
    localparam int INH_BIT = (gi == 0) ? 0 : gi + 1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]          cnt_ext;
    logic                 cond, inc;

    assign sel_lo[gi] = (bus.addr == LO_ADDR);
    assign sel_hi[gi] = (bus.addr == (LO_ADDR | 12'h080));

    if (gi >= 2) begin : g_hpm
      assign cond = evt_hit[gi-2];
`ifdef HPM_OVERFLOW_IRQ_EN
      // A counter write drops the increment, so it can never wrap that cycle.
      assign hpm_wrap[gi-2] = inc & ~(bus.wr & (sel_lo[gi] | sel_hi[gi])) & (&cnt_q);
`endif
    end else if (gi == 1) begin : g_instret
      assign cond = retire;
    end else begin : g_cycle
      assign cond = 1'b1;
    end

    assign inc = cond & ~inhibit_q[INH_BIT];

    always_comb begin
      cnt_d = cnt_q;
      if (bus.wr && sel_lo[gi])      cnt_d[31:0] = wval;
      else if (bus.wr && sel_hi[gi]) cnt_d[CNT_WIDTH-1:32] = wval[CNT_WIDTH-33:0];
      else if (inc)                  cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_ext    = 64'(cnt_q);
    assign cnt_lo[gi] = cnt_ext[31:0];
    assign cnt_hi[gi] = cnt_ext[63:32];
  end

  for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_evt
    localparam logic [11:0] EVT_ADDR = 12'(32'h323 + gi);

    logic [7:0] code_q, code_d;

    assign sel_evt[gi] = (bus.addr == EVT_ADDR);

    always_comb begin
      code_d = code_q;
      if (bus.wr && sel_evt[gi]) code_d = wval[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) code_q <= '0;
      else     code_q <= code_d;
    end

    // Code 0 maps to index 255 and codes above NUM_EVENTS to pad bits; all read 0.
    assign evt_hit[gi] = ev_pad[code_q - 8'd1];

`ifdef HPM_OVERFLOW_IRQ_EN
    logic of_q, of_d;

    always_comb begin
      of_d = of_q;
      if (bus.wr && sel_evt[gi]) of_d = wval[31];
      if (hpm_wrap[gi])          of_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) of_q <= 1'b0;
      else     of_q <= of_d;
    end

    assign of_flags[gi] = of_q;
`else
    assign of_flags[gi] = 1'b0;
`endif

    assign evt_rd[gi] = {of_flags[gi], 23'd0, code_q};
  end

  always_comb begin
`ifdef HPM_OVERFLOW_IRQ_EN
    overflow_irq_d = |of_flags;
`else
    overflow_irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_irq_q <= 1'b0;
    else     overflow_irq_q <= overflow_irq_d;
  end

  assign overflow_irq = overflow_irq_q;

endmodule

// File: tb/tb_mhpm_counters.sv
// Bench for mhpm_counters: directed CSR/event stimulus, per-cycle model compare, literal spot checks.
module tb_mhpm_counters;
  import mhpm_counters_pkg::*;

  localparam int NHPM = 4;
  localparam int CW   = 64;
  localparam int NEV  = 16;
  localparam logic [63:0] CMASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           retire = 1'b0;
  logic [NEV-1:0] event_vec = '0;
  logic           overflow_irq;

  mhpm_counters_if bus ();

  mhpm_counters #(.NUM_HPM(NHPM), .CNT_WIDTH(CW), .NUM_EVENTS(NEV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .retire(retire),
    .event_vec(event_vec),
    .overflow_irq(overflow_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model state indexed by architectural counter number (0 cycle, 2 instret, 3.. hpm).
  logic [63:0] m_cnt  [32];
  logic [7:0]  m_code [32];
  logic [31:0] m_of;
  logic [31:0] m_inh;
  logic        m_irq;

  function automatic bit impl(int n);
    return n == 0 || n == 2 || (n >= 3 && n < 3 + NHPM);
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m = '0;
    for (int n = 0; n < 32; n++) if (impl(n)) m[n] = 1'b1;
    return m;
  endfunction

  function automatic logic [32:0] m_read(input logic [11:0] a);
    int n;
    logic [32:0] r = {1'b1, 32'd0};
    if (a == 12'h320) r = {1'b0, m_inh};
    else if (a >= 12'h323 && a <= 12'h33F) begin
      n = int'(a - 12'h320);
      r = {1'b0, impl(n) ? {m_of[n], 23'd0, m_code[n]} : 32'd0};
    end else if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
      n = int'(a[4:0]);
      if (n != 1) r = {1'b0, a[7] ? m_cnt[n][63:32] : m_cnt[n][31:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] m_dout(input logic [11:0] a);
    logic [32:0] r = m_read(a);
    return r[31:0];
  endfunction

  function automatic logic m_ill(input logic [11:0] a);
    logic [32:0] r = m_read(a);
    return r[32];
  endfunction

  function automatic logic [31:0] m_wval();
    logic [31:0] old = m_dout(bus.addr);
    case (bus.write_mode)
      CSR_SET:   return old | bus.din;
      CSR_CLEAR: return old & ~bus.din;
      default:   return bus.din;
    endcase
  endfunction

  function automatic bit m_inc(int n);
    if (m_inh[n]) return 1'b0;
    if (n == 0) return 1'b1;
    if (n == 2) return retire;
    if (m_code[n] >= 8'd1 && int'(m_code[n]) <= NEV) return event_vec[int'(m_code[n]) - 1];
    return 1'b0;
  endfunction

  function automatic bit m_cnt_written(int n);
    return bus.wr && (bus.addr == 12'(32'hB00 + n) || bus.addr == 12'(32'hB80 + n));
  endfunction

  function automatic logic [63:0] m_cnt_next(int n);
    logic [63:0] v = m_cnt[n];
    logic [31:0] w = m_wval();
    if (bus.wr && bus.addr == 12'(32'hB00 + n))      v[31:0] = w;
    else if (bus.wr && bus.addr == 12'(32'hB80 + n)) v[63:32] = w;
    else if (m_inc(n))                               v = v + 64'd1;
    return v & CMASK;
  endfunction

  function automatic logic m_of_next(int n);
`ifdef HPM_OVERFLOW_IRQ_EN
    logic f = m_of[n];
    logic [31:0] w = m_wval();
    if (bus.wr && bus.addr == 12'(32'h320 + n)) f = w[31];
    if (!m_cnt_written(n) && m_inc(n) && m_cnt[n] == CMASK) f = 1'b1;
    return f;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 32; n++) begin
        m_cnt[n]  <= '0;
        m_code[n] <= '0;
      end
      m_of  <= '0;
      m_inh <= '0;
      m_irq <= 1'b0;
    end else begin
      for (int n = 0; n < 32; n++) begin
        if (impl(n)) begin
          m_cnt[n] <= m_cnt_next(n);
          if (n >= 3) begin
            m_of[n] <= m_of_next(n);
            if (bus.wr && bus.addr == 12'(32'h320 + n)) m_code[n] <= 8'(m_wval());
          end
        end
      end
      if (bus.wr && bus.addr == 12'h320) m_inh <= m_wval() & inh_mask();
      m_irq <= |m_of;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_dout", 64'(bus.dout), 64'(m_dout(bus.addr)));
      check("cmp_illegal", 64'(bus.illegal_address), 64'(m_ill(bus.addr)));
      check("cmp_irq", 64'(overflow_irq), 64'(m_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic csr(input logic [11:0] a, input write_mode_t m, input logic [31:0] d);
    bus.addr = a;
    bus.write_mode = m;
    bus.din = d;
    bus.wr = 1'b1;
    tick(1);
    bus.wr = 1'b0;
    $display("csr write addr=0x%03h mode=%s din=0x%08h", a, m.name(), d);
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp,
                      input logic exp_ill);
    bus.addr = a;
    #1;
    $display("read %s addr=0x%03h dout=0x%08h illegal=%0b", name, a, bus.dout, bus.illegal_address);
    check(name, 64'(bus.dout), 64'(exp));
    check({name, "_ill"}, 64'(bus.illegal_address), 64'(exp_ill));
  endtask

  task automatic irq_is(input string name, input logic exp);
    $display("irq %s overflow_irq=%0b", name, overflow_irq);
    check(name, 64'(overflow_irq), 64'(exp));
  endtask

  initial begin
    bus.addr = 12'hB00;
    bus.wr = 1'b0;
    bus.write_mode = CSR_WRITE;
    bus.din = '0;
    rst = 1'b1;
    tick(2);
    peek("rst_mcycle", 12'hB00, 32'd0, 1'b0);
    irq_is("rst_irq", 1'b0);
    rst = 1'b0;

    // free run
    tick(10);
    peek("mcycle_10", 12'hB00, 32'd10, 1'b0);
    check("model_mcycle_10", m_cnt[0], 64'd10);
    peek("minstret_0", 12'hB02, 32'd0, 1'b0);
    for (int k = 0; k < NHPM; k++) peek($sformatf("hpm%0d_0", 3 + k), 12'(32'hB03 + k), 32'd0, 1'b0);
    irq_is("irq_idle", 1'b0);

    // event counting and inhibit
    csr(12'h323, CSR_WRITE, 32'd2);
    for (int i = 0; i < 5; i++) begin
      event_vec = 16'h0002; tick(1);
      event_vec = '0;       tick(1);
    end
    csr(12'h320, CSR_SET, 32'h8);
    for (int i = 0; i < 3; i++) begin
      event_vec = 16'h0002; tick(1);
      event_vec = '0;       tick(1);
    end
    peek("hpm3_5", 12'hB03, 32'd5, 1'b0);
    check("model_hpm3_5", m_cnt[3], 64'd5);
    peek("inhibit_8", 12'h320, 32'h8, 1'b0);
    peek("evt3_code", 12'h323, 32'd2, 1'b0);
    peek("hpm7_absent", 12'hB07, 32'd0, 1'b0);
    peek("evt7_absent", 12'h327, 32'd0, 1'b0);
    peek("evt31_absent", 12'h33F, 32'd0, 1'b0);
    peek("addr_7c0", 12'h7C0, 32'd0, 1'b1);
    peek("addr_b01", 12'hB01, 32'd0, 1'b1);
    peek("addr_322", 12'h322, 32'd0, 1'b1);
    csr(12'h320, CSR_CLEAR, 32'h8);

    // minstret carry into the high half
    retire = 1'b1;
    csr(12'hB02, CSR_WRITE, 32'hFFFF_FFFF);
    csr(12'hB82, CSR_WRITE, 32'h0);
    peek("instret_lo_ff", 12'hB02, 32'hFFFF_FFFF, 1'b0);
    peek("instret_hi_0", 12'hB82, 32'h0, 1'b0);
    tick(1);
    peek("instret_lo_wrap", 12'hB02, 32'h0, 1'b0);
    peek("instret_hi_1", 12'hB82, 32'h1, 1'b0);
    retire = 1'b0;

    // write beats same-cycle increment; set/clear on inhibit
    event_vec = 16'h0002;
    csr(12'hB03, CSR_WRITE, 32'h100);
    event_vec = '0;
    peek("hpm3_written", 12'hB03, 32'h100, 1'b0);
    csr(12'h320, CSR_SET, 32'h5);
    csr(12'h320, CSR_CLEAR, 32'h1);
    peek("inhibit_4", 12'h320, 32'h4, 1'b0);

    // event code range
    csr(12'h324, CSR_WRITE, 32'd17);
    csr(12'h325, CSR_WRITE, 32'd16);
    event_vec = '1;
    tick(3);
    event_vec = '0;
    peek("hpm4_code17", 12'hB04, 32'd0, 1'b0);
    peek("hpm5_code16", 12'hB05, 32'd3, 1'b0);
    peek("hpm3_103", 12'hB03, 32'h103, 1'b0);
    csr(12'h326, CSR_WRITE, 32'hFFFF_FFFF);
`ifdef HPM_OVERFLOW_IRQ_EN
    peek("evt6_ones", 12'h326, 32'h8000_00FF, 1'b0);
`else
    peek("evt6_ones", 12'h326, 32'h0000_00FF, 1'b0);
`endif
    csr(12'h326, CSR_WRITE, 32'h0);
    tick(2);

    // 64-bit wrap of hpm3
    csr(12'hB03, CSR_WRITE, 32'hFFFF_FFFF);
    csr(12'hB83, CSR_WRITE, 32'hFFFF_FFFF);
    irq_is("irq_prewrap", 1'b0);
    event_vec = 16'h0002;
    tick(1);
    event_vec = '0;
    peek("hpm3_wrap_lo", 12'hB03, 32'h0, 1'b0);
    peek("hpm3_wrap_hi", 12'hB83, 32'h0, 1'b0);
`ifdef HPM_OVERFLOW_IRQ_EN
    peek("evt3_of", 12'h323, 32'h8000_0002, 1'b0);
    irq_is("irq_same_cycle", 1'b0);
    tick(1);
    irq_is("irq_rise", 1'b1);
    csr(12'h323, CSR_CLEAR, 32'h8000_0000);
    irq_is("irq_hold", 1'b1);
    tick(1);
    irq_is("irq_fall", 1'b0);
    peek("evt3_cleared", 12'h323, 32'h2, 1'b0);
`else
    peek("evt3_no_of", 12'h323, 32'h2, 1'b0);
    tick(1);
    irq_is("irq_tied", 1'b0);
`endif

    // asynchronous reset mid-count
    event_vec = 16'h0002;
    retire = 1'b1;
    tick(4);
    peek("hpm3_pre_rst", 12'hB03, 32'd4, 1'b0);
    rst = 1'b1;
    event_vec = '0;
    retire = 1'b0;
    peek("arst_mcycle", 12'hB00, 32'd0, 1'b0);
    peek("arst_hpm3", 12'hB03, 32'd0, 1'b0);
    peek("arst_inhibit", 12'h320, 32'd0, 1'b0);
    peek("arst_evt3", 12'h323, 32'd0, 1'b0);
    irq_is("arst_irq", 1'b0);
    tick(1);
    rst = 1'b0;
    tick(3);
    peek("mcycle_resume", 12'hB00, 32'd3, 1'b0);
    check("model_mcycle_resume", m_cnt[0], 64'd3);
    peek("instret_after_rst", 12'hB02, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
